// File: rtl/vend_pkg.sv
// Shared definitions for the vending-core arbiter: product and result codes,
// arbiter state encoding and the core-response decode.
package vend_pkg;

   localparam logic [1:0] PROD_APPLE  = 2'd0;
   localparam logic [1:0] PROD_BANANA = 2'd1;
   localparam logic [1:0] PROD_CARROT = 2'd2;
   localparam logic [1:0] PROD_DATE   = 2'd3;

   localparam logic [2:0] RSP_APPLE   = {1'b0, PROD_APPLE};
   localparam logic [2:0] RSP_BANANA  = {1'b0, PROD_BANANA};
   localparam logic [2:0] RSP_CARROT  = {1'b0, PROD_CARROT};
   localparam logic [2:0] RSP_DATE    = {1'b0, PROD_DATE};
   localparam logic [2:0] RSP_ERROR   = 3'd4;
   localparam logic [2:0] RSP_TIMEOUT = 3'd5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // Error beats any dispense; among dispenses the lowest product code wins.
   function automatic logic [2:0] resp_code(input logic err, input logic apple,
                                            input logic banana, input logic carrot);
      if (err)         return RSP_ERROR;
      else if (apple)  return RSP_APPLE;
      else if (banana) return RSP_BANANA;
      else if (carrot) return RSP_CARROT;
      else             return RSP_DATE;
   endfunction

endpackage

// File: rtl/vend_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int  NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic               valid,
   output logic [IW-1:0]      idx
);

   int            c;
   logic [IW-1:0] cand;

   // NOTE: every variable written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      c     = 0;
      cand  = '0;
      // Scan farthest-first so the candidate closest to ptr is written last.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         c = int'(ptr) + k;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         cand = IW'(c);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/vend_arbiter.sv
// Round-robin front end sharing one PurchaseManager core between NUM_REQ kiosks;
// every output is registered.
module vend_arbiter
   import vend_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [2*NUM_REQ-1:0]   req_product,
   input  logic [8*NUM_REQ-1:0]   req_credit,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     done,
   output logic [2:0]             rsp_code,
   output logic                   busy,
   output logic                   pm_buy,
   output logic [1:0]             pm_product,
   output logic [7:0]             pm_credit,
   input  logic                   pm_apple,
   input  logic                   pm_banana,
   input  logic                   pm_carrot,
   input  logic                   pm_date,
   input  logic                   pm_error
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state, state_n;
   logic [IW-1:0] ptr, ptr_n;
   logic [IW-1:0] owner, owner_n;
   logic [CW-1:0] cnt, cnt_n;

   logic [NUM_REQ-1:0] gnt_n, done_n;
   logic [2:0]         rsp_code_n;
   logic               busy_n, pm_buy_n;
   logic [1:0]         pm_product_n;
   logic [7:0]         pm_credit_n;

   logic          pick_valid;
   logic [IW-1:0] pick_idx;
   logic [1:0]    sel_product;
   logic [7:0]    sel_credit;
   logic          pm_any;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      sel_product = '0;
      sel_credit  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IW'(i)) begin
            sel_product = req_product[2*i +: 2];
            sel_credit  = req_credit[8*i +: 8];
         end
      end
   end

   assign pm_any = pm_error | pm_apple | pm_banana | pm_carrot | pm_date;

   always_comb begin
      state_n      = state;
      ptr_n        = ptr;
      owner_n      = owner;
      cnt_n        = cnt;
      gnt_n        = '0;
      done_n       = '0;
      rsp_code_n   = rsp_code;
      busy_n       = busy;
      pm_buy_n     = pm_buy;
      pm_product_n = pm_product;
      pm_credit_n  = pm_credit;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               gnt_n[pick_idx] = 1'b1;
               pm_product_n    = sel_product;
               pm_credit_n     = sel_credit;
               pm_buy_n        = 1'b1;
               busy_n          = 1'b1;
               ptr_n           = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
               owner_n         = pick_idx;
               cnt_n           = '0;
               state_n         = WAIT;
            end
         end
         WAIT: begin
            cnt_n = cnt + 1'b1;
            if (pm_any || cnt == CNT_LAST) begin
               rsp_code_n    = pm_any ? resp_code(pm_error, pm_apple, pm_banana, pm_carrot)
                                      : RSP_TIMEOUT;
               pm_buy_n      = 1'b0;
               done_n[owner] = 1'b1;
               state_n       = RELEASE;
            end
         end
         RELEASE: begin
            pm_credit_n = '0;
            busy_n      = 1'b0;
            state_n     = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         owner      <= '0;
         cnt        <= '0;
         gnt        <= '0;
         done       <= '0;
         rsp_code   <= '0;
         busy       <= 1'b0;
         pm_buy     <= 1'b0;
         pm_product <= '0;
         pm_credit  <= '0;
      end else begin
         state      <= state_n;
         ptr        <= ptr_n;
         owner      <= owner_n;
         cnt        <= cnt_n;
         gnt        <= gnt_n;
         done       <= done_n;
         rsp_code   <= rsp_code_n;
         busy       <= busy_n;
         pm_buy     <= pm_buy_n;
         pm_product <= pm_product_n;
         pm_credit  <= pm_credit_n;
      end
   end

endmodule
